// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: field widths, frame
// start marker default, FSM state encoding and the write payload type.
package loader_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned COUNT_W = 9;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // One program-memory write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } prog_wr_t;

  // States in which a frame is in flight.
  function automatic logic is_busy(input state_e s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: host side (halt, UART byte/level) and program-memory/status side.
//   master : drives halt, rx_data, rx_valid; observes writes and status
//   slave  : the loader itself
interface program_loader_if;
  import loader_pkg::*;

  logic                      halt;
  logic [BYTE_W-1:0]         rx_data;
  logic                      rx_valid;
  logic                      prog_we;
  logic [ADDR_W-1:0]         prog_addr;
  logic [BYTE_W-1:0]         prog_data;
  logic                      busy;
  logic                      load_done;
  logic                      load_err;
  logic [COUNT_W-1:0]        byte_count;

  modport master (
    output halt, rx_data, rx_valid,
    input  prog_we, prog_addr, prog_data, busy, load_done, load_err, byte_count
  );

  modport slave (
    input  halt, rx_data, rx_valid,
    output prog_we, prog_addr, prog_data, busy, load_done, load_err, byte_count
  );

endinterface

// File: rtl/program_loader_strobe_edge.sv
// Rising-edge detector for an asynchronous-to-protocol level strobe.
//   clk, rst  : clock, synchronous active-high reset
//   sig_i     : level input (registered here)
//   rise_c_o  : one-cycle pulse while registered level is 1 and its previous
//               registered value was 0 (combinational from two registers)
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_c_o
);

  logic sig_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      prev_q <= sig_q;
    end
  end

  assign rise_c_o = sig_q & ~prev_q;

endmodule

// File: rtl/program_loader.sv
// UART program loader: parses SYNC / length / data / checksum frames while the
// CPU is halted and writes the data bytes into program memory.
//   clk, rst : clock, synchronous active-high reset
//   bus      : program_loader_if.slave (halt, rx_data, rx_valid in;
//              prog_we/addr/data, busy, load_done, load_err, byte_count out)
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYC = 1_000_000,
  parameter logic [BYTE_W-1:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.slave   bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   rx_byte_q;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [COUNT_W-1:0]  byte_count_q, byte_count_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  prog_wr_t            wr_q, wr_d;
  logic                prog_we_q, prog_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic evt_c;
  logic timeout_c;
  logic abort_c;
  logic accept_c;
  logic start_c;
  logic last_c;

  strobe_edge u_edge (
    .clk      (clk),
    .rst      (rst),
    .sig_i    (bus.rx_valid),
    .rise_c_o (evt_c)
  );

  // Frame-level conditions; abort (halt drop or timeout) beats any byte event.
  assign timeout_c = is_busy(state_q) && (timer_q == TMR_W'(TIMEOUT_CYC));
  assign abort_c   = is_busy(state_q) && (!bus.halt || timeout_c);
  assign accept_c  = evt_c && is_busy(state_q) && !abort_c;
  assign start_c   = evt_c && bus.halt && (rx_byte_q == SYNC_BYTE) && !is_busy(state_q);
  assign last_c    = (byte_count_q + COUNT_W'(1)) == COUNT_W'(len_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start_c) state_d = ST_LEN;
      ST_LEN:  if (accept_c) state_d = (rx_byte_q == '0) ? ST_ERR : ST_DATA;
      ST_DATA: if (accept_c && last_c) state_d = ST_CSUM;
      ST_CSUM: if (accept_c) state_d = (rx_byte_q == sum_q) ? ST_DONE : ST_ERR;
      default: state_d = ST_IDLE;
    endcase
    if (abort_c) state_d = ST_ERR;
  end

  // Datapath / output next values.
  always_comb begin
    len_d        = len_q;
    byte_count_d = byte_count_q;
    sum_d        = sum_q;
    wr_d         = wr_q;
    prog_we_d    = 1'b0;

    if (start_c) begin
      byte_count_d = '0;
      sum_d        = '0;
    end

    if (accept_c) begin
      case (state_q)
        ST_LEN:  len_d = rx_byte_q;
        ST_DATA: begin
          prog_we_d    = 1'b1;
          wr_d.addr    = byte_count_q[ADDR_W-1:0];
          wr_d.data    = rx_byte_q;
          byte_count_d = byte_count_q + COUNT_W'(1);
          sum_d        = sum_q + rx_byte_q;
        end
        default: ;
      endcase
    end

    // Idle timer runs only while a frame stays in flight without a new byte.
    if (is_busy(state_q) && is_busy(state_d) && !accept_c)
      timer_d = timer_q + TMR_W'(1);
    else
      timer_d = '0;

    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_q    <= '0;
      len_q        <= '0;
      byte_count_q <= '0;
      sum_q        <= '0;
      timer_q      <= '0;
      wr_q         <= '0;
      prog_we_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_byte_q    <= bus.rx_data;
      len_q        <= len_d;
      byte_count_q <= byte_count_d;
      sum_q        <= sum_d;
      timer_q      <= timer_d;
      wr_q         <= wr_d;
      prog_we_q    <= prog_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.prog_we    = prog_we_q;
  assign bus.prog_addr  = wr_q.addr;
  assign bus.prog_data  = wr_q.data;
  assign bus.busy       = busy_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;
  assign bus.byte_count = byte_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes and
// status snapshots; a negedge monitor pops and compares them.
module tb_program_loader;

  localparam int unsigned TMO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader #(
    .TIMEOUT_CYC (TMO),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] cnt;
    logic [7:0] addr;
    logic [7:0] data;
  } stat_t;

  logic [15:0] wr_exp_q[$];
  stat_t       stat_q[$];
  string       stat_name_q[$];
  int          n_run  = 0;
  int          n_fail = 0;
  bit          stim_done = 1'b0;

  logic [15:0] exp_wr;
  stat_t       exp_st;
  stat_t       act_st;
  string       nm;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] a, input logic [7:0] b);
    wr_exp_q.push_back({a, b});
    send_byte(b);
  endtask

  task automatic expect_stat(input string name, input logic busy, input logic done,
                             input logic err, input logic [8:0] cnt,
                             input logic [7:0] a, input logic [7:0] d);
    stat_t s;
    s.busy = busy; s.done = done; s.err = err;
    s.cnt  = cnt;  s.addr = a;    s.data = d;
    stat_q.push_back(s);
    stat_name_q.push_back(name);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: writes, status snapshots, mutual-exclusion invariant, end of run.
  always @(negedge clk) begin
    if (bus.prog_we === 1'b1) begin
      n_run++;
      if (wr_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%02h data=%02h, required none",
                 bus.prog_addr, bus.prog_data);
      end else begin
        exp_wr = wr_exp_q.pop_front();
        if ({bus.prog_addr, bus.prog_data} !== exp_wr) begin
          n_fail++;
          $display("FAIL write: got %02h:%02h, required %02h:%02h",
                   bus.prog_addr, bus.prog_data, exp_wr[15:8], exp_wr[7:0]);
        end
      end
    end
    if (stat_q.size() != 0) begin
      exp_st = stat_q.pop_front();
      nm     = stat_name_q.pop_front();
      act_st = '{busy: bus.busy, done: bus.load_done, err: bus.load_err,
                 cnt: bus.byte_count, addr: bus.prog_addr, data: bus.prog_data};
      n_run++;
      if (act_st !== exp_st || bus.prog_we !== 1'b0) begin
        n_fail++;
        $display("FAIL %s: got busy=%b done=%b err=%b cnt=%0d addr=%02h data=%02h we=%b, required busy=%b done=%b err=%b cnt=%0d addr=%02h data=%02h we=0",
                 nm, act_st.busy, act_st.done, act_st.err, act_st.cnt, act_st.addr,
                 act_st.data, bus.prog_we, exp_st.busy, exp_st.done, exp_st.err,
                 exp_st.cnt, exp_st.addr, exp_st.data);
      end
    end
    if (bus.load_done === 1'b1 && bus.load_err === 1'b1) begin
      n_run++;
      n_fail++;
      $display("FAIL done_err_exclusive: got both high, required at most one");
    end
    if (stim_done) begin
      n_run++;
      if (wr_exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_writes: got %0d outstanding, required 0", wr_exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
    end
  end

  // Directed stimulus.
  initial begin
    logic [7:0] sum;
    rst          = 1'b1;
    bus.halt     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_stat("reset", 0, 0, 0, 9'd0, 8'h00, 8'h00);
    bus.halt = 1'b1;

    // Good 3-byte frame.
    send_byte(8'hA5);
    expect_stat("f1_start", 1, 0, 0, 9'd0, 8'h00, 8'h00);
    send_byte(8'h03);
    send_data(8'h00, 8'h11);
    send_data(8'h01, 8'h22);
    send_data(8'h02, 8'h33);
    send_byte(8'h66);
    expect_stat("f1_done", 0, 1, 0, 9'd3, 8'h02, 8'h33);

    // Bad checksum.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_data(8'h00, 8'h10);
    send_data(8'h01, 8'h20);
    send_byte(8'h31);
    expect_stat("f2_bad_csum", 0, 0, 1, 9'd2, 8'h01, 8'h20);

    // Zero length, then recovery.
    send_byte(8'hA5);
    send_byte(8'h00);
    expect_stat("f3_zero_len", 0, 0, 1, 9'd0, 8'h01, 8'h20);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_data(8'h00, 8'h7F);
    send_byte(8'h7F);
    expect_stat("f4_recover", 0, 1, 0, 9'd1, 8'h00, 8'h7F);

    // Timeout after one of four bytes.
    send_byte(8'hA5);
    send_byte(8'h04);
    send_data(8'h00, 8'h01);
    repeat (40) @(negedge clk);
    expect_stat("f5_pre_timeout", 1, 0, 0, 9'd1, 8'h00, 8'h01);
    repeat (TMO) @(negedge clk);
    expect_stat("f5_timeout", 0, 0, 1, 9'd1, 8'h00, 8'h01);

    // Halt drop mid-frame; later bytes must not write or restart.
    send_byte(8'hA5);
    send_byte(8'h03);
    send_data(8'h00, 8'hAA);
    @(negedge clk);
    bus.halt = 1'b0;
    @(negedge clk);
    expect_stat("f6_halt_drop", 0, 0, 1, 9'd1, 8'h00, 8'hAA);
    send_byte(8'hBB);
    send_byte(8'hA5);
    expect_stat("f6_after_halt", 0, 0, 1, 9'd1, 8'h00, 8'hAA);
    bus.halt = 1'b1;

    // Level held high for 50 cycles gives one write; then reset mid-frame.
    send_byte(8'hA5);
    send_byte(8'h03);
    wr_exp_q.push_back({8'h00, 8'h5A});
    @(negedge clk);
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    repeat (50) @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    expect_stat("f7_held_level", 1, 0, 0, 9'd1, 8'h00, 8'h5A);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_stat("f7_reset_mid", 0, 0, 0, 9'd0, 8'h00, 8'h00);
    send_byte(8'h6B);
    expect_stat("f7_idle_ignore", 0, 0, 0, 9'd0, 8'h00, 8'h00);

    // Maximum length frame: addresses 00..FE, no wrap.
    send_byte(8'hA5);
    send_byte(8'hFF);
    sum = 8'h00;
    for (int i = 0; i < 255; i++) begin
      send_data(8'(i), 8'(i));
      sum = sum + 8'(i);
    end
    send_byte(sum);
    expect_stat("f8_max_len", 0, 1, 0, 9'd255, 8'hFE, 8'hFE);

    repeat (5) @(negedge clk);
    stim_done = 1'b1;
  end

  // Run-time bound.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
